alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_pkg.sv | 47 ++++
 rtl/alu_issue_stage_ireg_file.sv | 37 +++
 rtl/alu_issue_stage.sv | 129 ++++++++++++
 tb/tb_alu_issue_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the issue stage and the downstream ALU:
// opcode values, LIMM flag meaning, FSM state encoding and the latched instruction.
package alu_issue_stage_pkg;

    localparam int REG_W = 32;
    localparam int IDX_W = 6;

    typedef enum logic [3:0] {
        OP_OR  = 4'h0,
        OP_XOR = 4'h1,
        OP_AND = 4'h2,
        OP_ADD = 4'h4,
        OP_SUB = 4'h5,
        OP_SHL = 4'h8,
        OP_SAR = 4'h9
    } alu_op_e;

    localparam logic LIMM_LOAD = 1'b1;
    localparam logic LIMM_ALU  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic             limm;
        logic [3:0]       op;
        logic [IDX_W-1:0] rd;
        logic [IDX_W-1:0] rs0;
        logic [IDX_W-1:0] rs1;
        logic [REG_W-1:0] imm;
    } instr_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_OR, OP_XOR, OP_AND, OP_ADD, OP_SUB, OP_SHL, OP_SAR: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_stage_ireg_file.sv
// Integer register file: two async read ports, one write port, one debug read port.
// Writes land on the rising edge; reset clears every entry asynchronously.
module ireg_file #(
    parameter int NREG  = 64,
    parameter int IDX_W = 6,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [DW-1:0]    i_wdata,
    input  logic [IDX_W-1:0] i_raddr0,
    input  logic [IDX_W-1:0] i_raddr1,
    input  logic [IDX_W-1:0] i_dbg_addr,
    output logic [DW-1:0]    o_rdata0,
    output logic [DW-1:0]    o_rdata1,
    output logic [DW-1:0]    o_dbg_data
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0   = r_mem[i_raddr0];
    assign o_rdata1   = r_mem[i_raddr1];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: IDLE -> READ -> EXEC -> WB, write-back on accept edge + 3, one instruction per 4 cycles.
// in_ready only in IDLE; illegal ops pulse err in READ and return to IDLE without a write.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int NREG = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_limm,
    input  logic [3:0]       in_op,
    input  logic [IDX_W-1:0] in_rd,
    input  logic [IDX_W-1:0] in_rs0,
    input  logic [IDX_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_imm,
    output logic [REG_W-1:0] alu_d0,
    output logic [REG_W-1:0] alu_d1,
    output logic [3:0]       alu_op,
    input  logic [REG_W-1:0] alu_dout,
    output logic             done,
    output logic             err,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic [REG_W-1:0] dbg_data
);

    state_e           r_state;
    state_e           w_state_nxt;
    instr_t           r_ins;
    logic [REG_W-1:0] r_alu_d0;
    logic [REG_W-1:0] r_alu_d1;
    logic [3:0]       r_alu_op;
    logic [REG_W-1:0] r_result;
    logic [REG_W-1:0] w_rdata0;
    logic [REG_W-1:0] w_rdata1;
    logic             w_accept;
    logic             w_legal;
    logic             w_we;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_legal  = (r_ins.limm == LIMM_LOAD) || op_is_legal(r_ins.op);

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        err         = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_READ;
            ST_READ: begin
                err         = !w_legal;
                w_state_nxt = w_legal ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: w_state_nxt = ST_WB;
            ST_WB: begin
                done        = 1'b1;
                w_we        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand registers double as the ALU-facing outputs, so they only move when leaving READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ins    <= '0;
            r_alu_d0 <= '0;
            r_alu_d1 <= '0;
            r_alu_op <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_ins.limm <= in_limm;
                r_ins.op   <= in_op;
                r_ins.rd   <= in_rd;
                r_ins.rs0  <= in_rs0;
                r_ins.rs1  <= in_rs1;
                r_ins.imm  <= in_imm;
            end
            if (r_state == ST_READ && w_legal) begin
                r_alu_op <= r_ins.op;
                if (r_ins.limm == LIMM_LOAD) begin
                    r_alu_d0 <= r_ins.imm;
                    r_alu_d1 <= '0;
                end else begin
                    r_alu_d0 <= w_rdata0;
                    r_alu_d1 <= w_rdata1;
                end
            end
            if (r_state == ST_EXEC) begin
                r_result <= (r_ins.limm == LIMM_LOAD) ? r_ins.imm : alu_dout;
            end
        end
    end

    assign alu_d0 = r_alu_d0;
    assign alu_d1 = r_alu_d1;
    assign alu_op = r_alu_op;

    ireg_file #(
        .NREG  (NREG),
        .IDX_W (IDX_W),
        .DW    (REG_W)
    ) u_ireg_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (r_ins.rd),
        .i_wdata    (r_result),
        .i_raddr0   (r_ins.rs0),
        .i_raddr1   (r_ins.rs1),
        .i_dbg_addr (dbg_addr),
        .o_rdata0   (w_rdata0),
        .o_rdata1   (w_rdata1),
        .o_dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU plus a register-array model of the
// architectural state; directed scenarios followed by a randomized instruction stream.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_limm;
    logic [3:0]  in_op;
    logic [5:0]  in_rd;
    logic [5:0]  in_rs0;
    logic [5:0]  in_rs1;
    logic [31:0] in_imm;
    logic [31:0] alu_d0;
    logic [31:0] alu_d1;
    logic [3:0]  alu_op;
    logic [31:0] alu_dout;
    logic        done;
    logic        err;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_data;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] mdl [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_issue_stage #(.NREG(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_limm  (in_limm),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs0   (in_rs0),
        .in_rs1   (in_rs1),
        .in_imm   (in_imm),
        .alu_d0   (alu_d0),
        .alu_d1   (alu_d1),
        .alu_op   (alu_op),
        .alu_dout (alu_dout),
        .done     (done),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0:    return a | b;
            4'h1:    return a ^ b;
            4'h2:    return a & b;
            4'h4:    return a + b;
            4'h5:    return a - b;
            4'h8:    return a << b;
            4'h9:    return 32'($signed(a) >>> b);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic op_ok(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9};
    endfunction

    always_comb alu_dout = alu_ref(alu_op, alu_d0, alu_d1);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input logic limm, input logic [3:0] op, input logic [5:0] rd,
                         input logic [5:0] rs0, input logic [5:0] rs1, input logic [31:0] imm);
        in_limm = limm; in_op = op; in_rd = rd; in_rs0 = rs0; in_rs1 = rs1; in_imm = imm;
    endtask

    // Full single-instruction check: timing of err/done, ALU operands in EXEC, written value.
    task automatic issue(input logic limm, input logic [3:0] op, input logic [5:0] rd,
                         input logic [5:0] rs0, input logic [5:0] rs1, input logic [31:0] imm);
        logic        ok;
        logic [31:0] a, b, res;
        @(negedge clk);
        drive(limm, op, rd, rs0, rs1, imm);
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok  = limm || op_ok(op);
        a   = mdl[rs0];
        b   = mdl[rs1];
        res = limm ? imm : alu_ref(op, a, b);
        chk("read_ready", in_ready, 0);
        chk("read_err", err, ok ? 0 : 1);
        chk("read_done", done, 0);
        if (!ok) begin
            @(posedge clk); #1;
            chk("ill_ready", in_ready, 1);
            chk("ill_err_end", err, 0);
            chk("ill_done", done, 0);
            dbg_addr = rd; #1;
            chk("ill_nowrite", dbg_data, mdl[rd]);
            return;
        end
        @(posedge clk); #1;
        chk("exec_d0", alu_d0, limm ? imm : a);
        if (!limm) begin
            chk("exec_d1", alu_d1, b);
            chk("exec_op", alu_op, op);
        end
        chk("exec_done", done, 0);
        @(posedge clk); #1;
        chk("wb_done", done, 1);
        chk("wb_ready", in_ready, 0);
        @(posedge clk); #1;
        mdl[rd] = res;
        chk("post_done", done, 0);
        chk("post_ready", in_ready, 1);
        dbg_addr = rd; #1;
        chk("wb_data", dbg_data, res);
    endtask

    task automatic dbg_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        dbg_addr = a; #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  b_rd  [3];
        logic [5:0]  b_rs0 [3];
        logic [5:0]  b_rs1 [3];
        logic [3:0]  b_op  [3];
        int          t_prev;
        int          t_now;
        int          done_seen;

        rst_n = 1'b0; in_valid = 1'b0; dbg_addr = '0;
        drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0, 32'h0);
        for (int i = 0; i < 64; i++) mdl[i] = 32'h0;

        #22;
        chk("rst_ready", in_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_d0", alu_d0, 0);
        chk("rst_d1", alu_d1, 0);
        chk("rst_op", alu_op, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 64; i++) dbg_chk("rst_sweep", 6'(i), 32'h0);

        issue(1'b1, 4'h0, 6'd3, 6'd0, 6'd0, 32'd3);
        issue(1'b1, 4'h0, 6'd4, 6'd0, 6'd0, 32'd7);
        issue(1'b0, 4'h4, 6'd5, 6'd3, 6'd4, 32'h0);
        dbg_chk("add_r5", 6'd5, 32'd10);

        issue(1'b1, 4'h0, 6'd1, 6'd0, 6'd0, 32'h8000_0000);
        issue(1'b1, 4'h0, 6'd2, 6'd0, 6'd0, 32'd4);
        issue(1'b0, 4'h9, 6'd6, 6'd1, 6'd2, 32'h0);
        dbg_chk("sar_r6", 6'd6, 32'hF800_0000);
        issue(1'b0, 4'h5, 6'd7, 6'd2, 6'd1, 32'h0);
        dbg_chk("sub_r7", 6'd7, 32'h8000_0004);

        issue(1'b0, 4'h6, 6'd5, 6'd3, 6'd4, 32'h0);
        dbg_chk("ill_r5", 6'd5, 32'd10);

        // Back-to-back: in_valid never drops, accepts must be exactly 4 cycles apart.
        b_op[0] = 4'h4; b_rd[0] = 6'd5;  b_rs0[0] = 6'd5;  b_rs1[0] = 6'd5;
        b_op[1] = 4'h4; b_rd[1] = 6'd11; b_rs0[1] = 6'd5;  b_rs1[1] = 6'd3;
        b_op[2] = 4'h1; b_rd[2] = 6'd12; b_rs0[2] = 6'd11; b_rs1[2] = 6'd4;
        @(negedge clk);
        drive(1'b0, b_op[0], b_rd[0], b_rs0[0], b_rs1[0], 32'h0);
        in_valid = 1'b1;
        wait_ready();
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            t_now = cyc;
            if (k > 0) chk("b2b_spacing", 32'(t_now - t_prev), 32'd4);
            t_prev = t_now;
            mdl[b_rd[k]] = alu_ref(b_op[k], mdl[b_rs0[k]], mdl[b_rs1[k]]);
            if (k < 2) drive(1'b0, b_op[k+1], b_rd[k+1], b_rs0[k+1], b_rs1[k+1], 32'h0);
            else in_valid = 1'b0;
            for (int j = 0; j < 3; j++) begin
                chk("b2b_busy", in_ready, 0);
                @(posedge clk); #1;
            end
            chk("b2b_free", in_ready, 1);
        end
        dbg_chk("b2b_r5", 6'd5, 32'd20);
        dbg_chk("b2b_r11", 6'd11, 32'd23);
        dbg_chk("b2b_r12", 6'd12, 32'd16);

        // Reset while the LIMM is in EXEC: nothing may be written and done must stay low.
        @(negedge clk);
        drive(1'b1, 4'h0, 6'd9, 6'd0, 6'd0, 32'h0000_1234);
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_exec_d0", alu_d0, 32'h1234);
        rst_n = 1'b0; #1;
        chk("abort_done", done, 0);
        chk("abort_d0", alu_d0, 0);
        chk("abort_op", alu_op, 0);
        chk("abort_err", err, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
        done_seen = 0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_ready", in_ready, 1);
        dbg_chk("abort_r9", 6'd9, 32'h0);
        dbg_chk("abort_r5", 6'd5, 32'h0);

        for (int i = 0; i < 6; i++) issue(1'b1, 4'h0, 6'(i), 6'd0, 6'd0, $urandom);
        for (int n = 0; n < 40; n++) begin
            logic        r_limm;
            logic [3:0]  r_op;
            logic [31:0] r_imm;
            r_limm = ($urandom_range(0, 3) == 0);
            r_op   = 4'($urandom_range(0, 15));
            r_imm  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            issue(r_limm, r_op, 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                  6'($urandom_range(0, 15)), r_imm);
        end
        for (int i = 0; i < 16; i++) dbg_chk("final_sweep", 6'(i), mdl[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
